// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store access controller.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

  // Size code 2'b11 is handled as a word access.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addrLo[0];
      default: bad = (addrLo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Replicates store data across byte lanes and builds the matching write mask.
module lsu_store_align
  import lsu_pkg::*;
(
  input  logic [31:0] wdata_in,
  input  logic [1:0]  size_in,
  input  logic [1:0]  addr_lo_in,
  output logic [31:0] dm_wdata_out,
  output logic [3:0]  dm_wmask_out
);

  always_comb begin
    dm_wdata_out = wdata_in;
    dm_wmask_out = 4'b1111;
    case (size_in)
      SIZE_B: begin
        dm_wdata_out = {4{wdata_in[7:0]}};
        dm_wmask_out = 4'b0001 << addr_lo_in;
      end
      SIZE_H: begin
        dm_wdata_out = {2{wdata_in[15:0]}};
        dm_wmask_out = addr_lo_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dm_wdata_out = wdata_in;
        dm_wmask_out = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Sequences execute-stage loads/stores onto the data-memory req/ack port,
// stalling the pipeline and holding load-extraction controls between loads.
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  output logic        stall_out,
  output logic        dm_req_out,
  output logic        dm_we_out,
  output logic [31:0] dm_addr_out,
  output logic [31:0] dm_wdata_out,
  output logic [3:0]  dm_wmask_out,
  input  logic        dm_ack_in,
  input  logic [31:0] dm_rdata_in,
  output logic [31:0] dmdata_out,
  output logic [1:0]  lu_addr_1_to_0_out,
  output logic [1:0]  lu_size_out,
  output logic        lu_unsigned_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  timeoutCnt_q;
  logic              capWe_q;
  logic [31:0]       capAddr_q;
  logic [1:0]        capSize_q;
  logic              capUnsigned_q;
  logic [31:0]       capWdata_q;
  logic [3:0]        capWmask_q;
  logic              errBus_q;
  logic [31:0]       dmdata_q;
  logic [1:0]        luAddr_q;
  logic [1:0]        luSize_q;
  logic              luUnsigned_q;

  logic [31:0]       alignWdata;
  logic [3:0]        alignWmask;
  logic              reqMisaligned;
  logic              timeoutHit;

  lsu_store_align u_store_align (
    .wdata_in     (wdata_in),
    .size_in      (size_in),
    .addr_lo_in   (addr_in[1:0]),
    .dm_wdata_out (alignWdata),
    .dm_wmask_out (alignWmask)
  );

  assign reqMisaligned = isMisaligned(size_in, addr_in[1:0]);
  assign timeoutHit    = TIMEOUT_EN && (timeoutCnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Ack has priority over timeout when both land in the same REQ cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_req_in) state_d = reqMisaligned ? ERR : REQ;
      REQ: begin
        if (dm_ack_in)       state_d = DONE;
        else if (timeoutHit) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      timeoutCnt_q  <= '0;
      capWe_q       <= 1'b0;
      capAddr_q     <= '0;
      capSize_q     <= '0;
      capUnsigned_q <= 1'b0;
      capWdata_q    <= '0;
      capWmask_q    <= '0;
      errBus_q      <= 1'b0;
      dmdata_q      <= '0;
      luAddr_q      <= '0;
      luSize_q      <= '0;
      luUnsigned_q  <= 1'b0;
    end else begin
      timeoutCnt_q <= (state_q == REQ) ? timeoutCnt_q + CNT_W'(1) : '0;
      if (state_q == IDLE && mem_req_in) begin
        capWe_q       <= mem_we_in;
        capAddr_q     <= addr_in;
        capSize_q     <= size_in;
        capUnsigned_q <= unsigned_in;
        capWdata_q    <= alignWdata;
        capWmask_q    <= mem_we_in ? alignWmask : 4'b0000;
        errBus_q      <= 1'b0;
      end
      if (state_q == REQ && !dm_ack_in && timeoutHit) errBus_q <= 1'b1;
      // Load-extraction controls move only when a load actually completes.
      if (state_q == REQ && dm_ack_in && !capWe_q) begin
        dmdata_q     <= dm_rdata_in;
        luAddr_q     <= capAddr_q[1:0];
        luSize_q     <= capSize_q;
        luUnsigned_q <= capUnsigned_q;
      end
    end
  end

  always_comb begin
    stall_out      = 1'b0;
    dm_req_out     = 1'b0;
    dm_we_out      = 1'b0;
    dm_wmask_out   = 4'b0000;
    load_valid_out = 1'b0;
    misaligned_out = 1'b0;
    bus_error_out  = 1'b0;
    case (state_q)
      IDLE: stall_out = mem_req_in;
      REQ: begin
        stall_out    = 1'b1;
        dm_req_out   = 1'b1;
        dm_we_out    = capWe_q;
        dm_wmask_out = capWmask_q;
      end
      DONE: load_valid_out = !capWe_q;
      ERR: begin
        misaligned_out = !errBus_q;
        bus_error_out  = errBus_q;
      end
      default: stall_out = 1'b0;
    endcase
  end

  assign dm_addr_out        = {capAddr_q[31:2], 2'b00};
  assign dm_wdata_out       = capWdata_q;
  assign dmdata_out         = dmdata_q;
  assign lu_addr_1_to_0_out = luAddr_q;
  assign lu_size_out        = luSize_q;
  assign lu_unsigned_out    = luUnsigned_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed-vector bench for lsu_access_ctrl with hand-computed expectations.
module tb_lsu_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReq, memWe, unsignedSel;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        stall, dmReq, dmWe;
  logic [31:0] dmAddr, dmWdata;
  logic [3:0]  dmWmask;
  logic        dmAck;
  logic [31:0] dmRdata, dmdata;
  logic [1:0]  luAddr, luSize;
  logic        luUnsigned, loadValid, misaligned, busError;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  lsu_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk_in(clk), .reset_in(rst),
    .mem_req_in(memReq), .mem_we_in(memWe), .addr_in(addr), .wdata_in(wdata),
    .size_in(size), .unsigned_in(unsignedSel),
    .stall_out(stall), .dm_req_out(dmReq), .dm_we_out(dmWe),
    .dm_addr_out(dmAddr), .dm_wdata_out(dmWdata), .dm_wmask_out(dmWmask),
    .dm_ack_in(dmAck), .dm_rdata_in(dmRdata),
    .dmdata_out(dmdata), .lu_addr_1_to_0_out(luAddr), .lu_size_out(luSize),
    .lu_unsigned_out(luUnsigned), .load_valid_out(loadValid),
    .misaligned_out(misaligned), .bus_error_out(busError)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] sz, input logic uns);
    memReq = req; memWe = we; addr = a; wdata = d; size = sz; unsignedSel = uns;
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic nextCycle;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; dmAck = 1'b0; dmRdata = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    nextCycle; nextCycle; #1;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_dmreq", dmReq, 0);
    checkOutput("rst_dmdata", dmdata, 0);
    checkOutput("rst_pulses", {loadValid, misaligned, busError}, 0);
    rst = 1'b0;

    // LW 0x100, ack on first REQ cycle
    nextCycle;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0); #1;
    checkOutput("lw_stall_idle", stall, 1);
    checkOutput("lw_noreq_idle", dmReq, 0);
    nextCycle;
    dmAck = 1'b1; dmRdata = 32'hDEADBEEF; #1;
    checkOutput("lw_req", dmReq, 1);
    checkOutput("lw_stall_req", stall, 1);
    checkOutput("lw_addr", dmAddr, 32'h100);
    checkOutput("lw_we", dmWe, 0);
    checkOutput("lw_mask", dmWmask, 0);
    nextCycle;
    dmAck = 1'b0; #1;
    checkOutput("lw_stall_done", stall, 0);
    checkOutput("lw_valid", loadValid, 1);
    checkOutput("lw_dmdata", dmdata, 32'hDEADBEEF);
    checkOutput("lw_lusize", luSize, 2'b10);
    memReq = 1'b0;
    nextCycle; #1;
    checkOutput("lw_valid_pulse", loadValid, 0);

    // SB 0x203 data 0xA5, ack in third REQ cycle
    applyStimulus(1'b1, 1'b1, 32'h203, 32'h000000A5, 2'b00, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      nextCycle;
      dmAck = (i == 3); #1;
      checkOutput($sformatf("sb_req%0d", i), dmReq, 1);
      checkOutput($sformatf("sb_wdata%0d", i), dmWdata, 32'hA5A5A5A5);
      checkOutput($sformatf("sb_mask%0d", i), dmWmask, 4'b1000);
    end
    checkOutput("sb_we", dmWe, 1);
    checkOutput("sb_addr", dmAddr, 32'h200);
    nextCycle;
    dmAck = 1'b0; #1;
    checkOutput("sb_done_req", dmReq, 0);
    checkOutput("sb_no_valid", loadValid, 0);
    checkOutput("sb_dmdata_hold", dmdata, 32'hDEADBEEF);
    memReq = 1'b0;
    nextCycle;

    // SH 0x301 is misaligned
    applyStimulus(1'b1, 1'b1, 32'h301, 32'h0000BEEF, 2'b01, 1'b0); #1;
    checkOutput("sh_mis_stall_idle", stall, 1);
    nextCycle; #1;
    checkOutput("sh_mis_pulse", misaligned, 1);
    checkOutput("sh_mis_noreq", dmReq, 0);
    checkOutput("sh_mis_stall", stall, 0);
    checkOutput("sh_mis_nobus", busError, 0);
    memReq = 1'b0;
    nextCycle; #1;
    checkOutput("sh_mis_once", misaligned, 0);

    // LBU 0x402 with no ack: 16 REQ cycles then a bus error
    applyStimulus(1'b1, 1'b0, 32'h402, 32'h0, 2'b00, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      nextCycle; #1;
      checkOutput($sformatf("to_req%0d", i), dmReq, 1);
      checkOutput($sformatf("to_nobus%0d", i), busError, 0);
    end
    nextCycle; #1;
    checkOutput("to_bus_pulse", busError, 1);
    checkOutput("to_nomis", misaligned, 0);
    checkOutput("to_req_drop", dmReq, 0);
    checkOutput("to_stall", stall, 0);
    memReq = 1'b0;
    nextCycle; #1;
    checkOutput("to_bus_once", busError, 0);
    nextCycle;
    dmAck = 1'b1; dmRdata = 32'h11111111; #1;
    checkOutput("late_ack_noreq", dmReq, 0);
    nextCycle;
    dmAck = 1'b0; #1;
    checkOutput("late_ack_novalid", loadValid, 0);
    checkOutput("late_ack_dmdata", dmdata, 32'hDEADBEEF);
    checkOutput("late_ack_lu_uns", luUnsigned, 0);

    // SH 0x502 data 0x1234
    applyStimulus(1'b1, 1'b1, 32'h502, 32'h00001234, 2'b01, 1'b0);
    nextCycle;
    dmAck = 1'b1; #1;
    checkOutput("sh_wdata", dmWdata, 32'h12341234);
    checkOutput("sh_mask", dmWmask, 4'b1100);
    checkOutput("sh_addr", dmAddr, 32'h500);
    nextCycle;
    dmAck = 1'b0; #1;
    checkOutput("sh_no_valid", loadValid, 0);
    memReq = 1'b0;
    nextCycle;

    // LHU 0x802 captures offset, size and unsigned flag
    applyStimulus(1'b1, 1'b0, 32'h802, 32'h0, 2'b01, 1'b1);
    nextCycle;
    dmAck = 1'b1; dmRdata = 32'h89ABCDEF; #1;
    checkOutput("lhu_mask", dmWmask, 0);
    nextCycle;
    dmAck = 1'b0; #1;
    checkOutput("lhu_valid", loadValid, 1);
    checkOutput("lhu_dmdata", dmdata, 32'h89ABCDEF);
    checkOutput("lhu_luaddr", luAddr, 2'b10);
    checkOutput("lhu_lusize", luSize, 2'b01);
    checkOutput("lhu_luuns", luUnsigned, 1);
    memReq = 1'b0;
    nextCycle;

    // Reset during the second REQ cycle of a load
    applyStimulus(1'b1, 1'b0, 32'h604, 32'h0, 2'b10, 1'b0);
    nextCycle; nextCycle;
    rst = 1'b1; #1;
    checkOutput("mid_rst_req_before", dmReq, 1);
    nextCycle;
    rst = 1'b0; memReq = 1'b0; #1;
    checkOutput("mid_rst_req", dmReq, 0);
    checkOutput("mid_rst_stall", stall, 0);
    checkOutput("mid_rst_pulses", {loadValid, misaligned, busError}, 0);
    checkOutput("mid_rst_dmdata", dmdata, 0);
    nextCycle; #1;
    checkOutput("mid_rst_pulses2", {loadValid, misaligned, busError}, 0);

    // Fresh LW 0x700 after reset
    applyStimulus(1'b1, 1'b0, 32'h700, 32'h0, 2'b10, 1'b0);
    nextCycle;
    dmAck = 1'b1; dmRdata = 32'hCAFEF00D; #1;
    checkOutput("post_rst_addr", dmAddr, 32'h700);
    nextCycle;
    dmAck = 1'b0; #1;
    checkOutput("post_rst_valid", loadValid, 1);
    checkOutput("post_rst_dmdata", dmdata, 32'hCAFEF00D);
    checkOutput("post_rst_luaddr", luAddr, 2'b00);
    memReq = 1'b0;
    nextCycle;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
